// File: rtl/fp_sqrt.sv
// fp_sqrt: iterative fixed-point square root, one result bit per clock.
// Signed Q(W-FRAC).FRAC radicand in, unsigned Q(W-FRAC).FRAC root out.
// The fixed N+1 cycle latency keeps timing predictable for the divider stage that follows.
module fp_sqrt #(
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int ROUND = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] din,
  output logic         busy,
  output logic         done,
  output logic         neg_err,
  output logic [W-1:0] root
);

  localparam int RW = W + FRAC;        // radicand width
  localparam int N  = RW / 2;          // root width / iteration count
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] rad, rad_nxt;
  logic [N+1:0]  rem, rem_nxt;
  logic [N-1:0]  q, q_nxt;
  logic          busy_nxt, done_nxt, neg_nxt;
  logic [W-1:0]  root_nxt;

  logic [N+3:0]  acc, trial;
  logic [N+1:0]  rem_step;
  logic [N-1:0]  q_step, q_final;

  // One restoring iteration: bring down two radicand bits, trial-subtract (q<<2)|1.
  // The working value is two bits wider than the remainder register so the
  // shifted-in remainder and the subtraction sign never overflow; the kept
  // remainder always fits back into N+2 bits.
  always_comb begin
    acc   = {rem, rad[RW-1 -: 2]};
    trial = acc - {2'b00, q, 2'b01};
    if (!trial[N+3]) begin
      rem_step = trial[N+1:0];
      q_step   = {q[N-2:0], 1'b1};
    end else begin
      rem_step = acc[N+1:0];
      q_step   = {q[N-2:0], 1'b0};
    end
    q_final = q_step;
    if (ROUND != 0 && rem_step > {2'b00, q_step})
      q_final = q_step + 1'b1;
  end

  // Next-state and output logic for the IDLE/CALC sequencer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rad_nxt   = rad;
    rem_nxt   = rem;
    q_nxt     = q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    neg_nxt   = neg_err;
    root_nxt  = root;
    unique case (state)
      IDLE: begin
        if (start) begin
          neg_nxt   = din[W-1];
          rad_nxt   = din[W-1] ? '0 : {din, {FRAC{1'b0}}};
          rem_nxt   = '0;
          q_nxt     = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        rad_nxt = {rad[RW-3:0], 2'b00};
        rem_nxt = rem_step;
        q_nxt   = q_step;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          root_nxt  = {{(W-N){1'b0}}, q_final};
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rad     <= '0;
      rem     <= '0;
      q       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      neg_err <= 1'b0;
      root    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rad     <= rad_nxt;
      rem     <= rem_nxt;
      q       <= q_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      neg_err <= neg_nxt;
      root    <= root_nxt;
    end
  end

endmodule

// File: tb/tb_fp_sqrt.sv
// tb_fp_sqrt: scoreboard bench for fp_sqrt (rounding and truncating instances side by side).
module tb_fp_sqrt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] din = '0;
  logic        busy_r, done_r, neg_r;
  logic [15:0] root_r;
  logic        busy_t, done_t, neg_t;
  logic [15:0] root_t;

  fp_sqrt #(.W(16), .FRAC(8), .ROUND(1)) dut_r (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .busy(busy_r), .done(done_r), .neg_err(neg_r), .root(root_r)
  );

  fp_sqrt #(.W(16), .FRAC(8), .ROUND(0)) dut_t (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .busy(busy_t), .done(done_t), .neg_err(neg_t), .root(root_t)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rnd;
    logic [15:0] trn;
    logic        neg;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;

  // Reference: largest r with r*r <= din<<8, optionally rounded to nearest.
  function automatic logic [15:0] ref_sqrt(input logic [15:0] d, input bit rnd);
    longint rr, r;
    if (d[15]) return 16'h0000;
    rr = longint'(d) << 8;
    r  = 0;
    while ((r + 1) * (r + 1) <= rr) r++;
    if (rnd && (rr - r * r > r)) r++;
    return 16'(r);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Drive one cycle of stimulus; record an expectation if the DUT will accept it.
  task automatic step(input logic s, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    start = s;
    din   = d;
    if (s && !busy_r && !rst) begin
      e.rnd = ref_sqrt(d, 1'b1);
      e.trn = ref_sqrt(d, 1'b0);
      e.neg = d[15];
      e.due = cycle + 13;
      q.push_back(e);
    end
  endtask

  // Issue an op, optionally poking start with junk while it runs.
  task automatic op(input logic [15:0] d, input bit noisy);
    step(1'b1, d);
    repeat (12) step(noisy ? 1'($urandom_range(0, 1)) : 1'b0, 16'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      step(1'b0, 16'($urandom));
      n++;
    end
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding", q.size());
      q.delete();
    end
  endtask

  // Monitor: sample after each rising edge and compare against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    cycle = cycle + 1;
    #1;
    if (!rst) begin
      if (done_r) begin
        if (q.size() == 0) begin
          failures++;
          checks++;
          $display("FAIL unexpected_done: got done=1 expected none (root=0x%04h)", root_r);
        end else begin
          e = q.pop_front();
          check("latency_cycle", 16'(cycle), 16'(e.due));
          check("root_round", root_r, e.rnd);
          check("root_trunc", root_t, e.trn);
          check("neg_err", {15'b0, neg_r}, {15'b0, e.neg});
          check("done_trunc", {15'b0, done_t}, 16'h0001);
          check("busy_at_done", {15'b0, busy_r}, 16'h0000);
        end
      end else if (q.size() != 0 && cycle < q[0].due) begin
        check("busy_during_op", {15'b0, busy_r}, 16'h0001);
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", {15'b0, busy_r}, 16'h0000);
    check("reset_done", {15'b0, done_r}, 16'h0000);
    check("reset_neg", {15'b0, neg_r}, 16'h0000);
    check("reset_root", root_r, 16'h0000);
    rst = 1'b0;

    // Directed values with hand-derived roots.
    op(16'h0400, 1'b0); drain(); check("dir_4p0", root_r, 16'h0200);
    op(16'h0200, 1'b1); drain(); check("dir_2p0", root_r, 16'h016A);
    op(16'h0001, 1'b1); drain(); check("dir_lsb", root_r, 16'h0010);
    op(16'h7FFF, 1'b1); drain(); check("dir_max", root_r, 16'h0B50);
    op(16'h0003, 1'b0); drain();
    check("dir_3_round", root_r, 16'h001C);
    check("dir_3_trunc", root_t, 16'h001B);
    op(16'hFFFF, 1'b1); drain();
    check("dir_neg_root", root_r, 16'h0000);
    check("dir_neg_flag", {15'b0, neg_r}, 16'h0001);
    op(16'h0100, 1'b0); drain();
    check("dir_1p0", root_r, 16'h0100);
    check("dir_1p0_neg", {15'b0, neg_r}, 16'h0000);
    op(16'h0000, 1'b1); drain(); check("dir_zero", root_r, 16'h0000);
    op(16'h8000, 1'b1); drain(); check("dir_most_neg", root_r, 16'h0000);

    // Back-to-back: second start lands on the done cycle.
    op(16'h0400, 1'b0);
    op(16'h0003, 1'b0);
    op(16'h7FFF, 1'b0);
    drain();

    // Randomised operands, random gaps, random junk starts while busy.
    for (int i = 0; i < 40; i++) begin
      op(16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) drain();
      else repeat ($urandom_range(0, 3)) step(1'b0, 16'($urandom));
    end
    drain();

    // Abort at iteration 6: reset takes effect on the sixth iteration edge.
    step(1'b1, 16'h0400);
    repeat (5) step(1'b0, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #2;
    check("abort_busy", {15'b0, busy_r}, 16'h0000);
    check("abort_done", {15'b0, done_r}, 16'h0000);
    check("abort_root", root_r, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) step(1'b0, 16'h0000);
    op(16'h0200, 1'b0); drain(); check("after_abort", root_r, 16'h016A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
